// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I boot controller: FSM state encoding and
// the default halt instruction.
`timescale 1ns/1ps
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } boot_state_t;

    // ebreak
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

endpackage

// File: rtl/boot_ctrl_if.sv
// Loader stream plus instruction-memory write port of the boot controller.
// The slave side is the controller; the master side feeds words and sees writes.
`timescale 1ns/1ps
interface boot_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();

    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
`timescale 1ns/1ps
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != '1)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/boot_ctrl.sv
// Boot controller: streams a program into instruction memory, holds the core
// in reset for a few cycles, then runs it until halt, cycle limit or abort.
`timescale 1ns/1ps
module boot_ctrl
    import rv32i_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 32,
    parameter int                RST_HOLD   = 2,
    parameter logic [31:0]       MAX_CYCLES = 32'd0,
    parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(EBREAK_INSTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    boot_ctrl_if.slave        ld_bus,
    output logic              core_rst,
    output logic              core_en,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr_i,
    output logic [31:0]       cycle_cnt,
    output logic              done,
    output logic              timeout,
    output logic              load_ovf,
    output logic              busy
);

    localparam int                HOLD_W   = $clog2(RST_HOLD + 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    boot_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              done_reg, done_next;
    logic              timeout_reg, timeout_next;
    logic              ovf_reg, ovf_next;
    logic              start_load;
    logic [HOLD_W-1:0] hold_cnt;

    logic accept, addr_at_max, halt_hit, limit_hit, hold_last;

    assign accept      = (state_reg == ST_LOAD) && ld_bus.ld_valid;
    assign addr_at_max = (addr_reg == ADDR_MAX);
    assign halt_hit    = instr_valid && (instr_i == HALT_INSTR);
    // Compare against the pre-increment count so the limit lands on the count's own edge.
    assign limit_hit   = (MAX_CYCLES != 32'd0) && (cycle_cnt == MAX_CYCLES - 32'd1);
    assign hold_last   = (hold_cnt == HOLD_W'(RST_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            done_reg    <= 1'b0;
            timeout_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            done_reg    <= done_next;
            timeout_reg <= timeout_next;
            ovf_reg     <= ovf_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        done_next    = done_reg;
        timeout_next = timeout_reg;
        ovf_next     = ovf_reg;
        start_load   = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next   = ST_LOAD;
                    start_load   = 1'b1;
                    addr_next    = '0;
                    done_next    = 1'b0;
                    timeout_next = 1'b0;
                    ovf_next     = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (!addr_at_max) begin
                        addr_next = addr_reg + ADDR_W'(1);
                    end
                    if (ld_bus.ld_last) begin
                        state_next = ST_HOLD;
                    end else if (addr_at_max) begin
                        state_next = ST_HOLD;
                        ovf_next   = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_last) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_hit) begin
                    state_next   = ST_DONE;
                    done_next    = 1'b1;
                    timeout_next = 1'b0;
                end else if (limit_hit) begin
                    state_next   = ST_DONE;
                    done_next    = 1'b1;
                    timeout_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Abort overrides everything and leaves the status flags as they were.
        if (abort) begin
            state_next   = ST_IDLE;
            addr_next    = addr_reg;
            done_next    = done_reg;
            timeout_next = timeout_reg;
            ovf_next     = ovf_reg;
            start_load   = 1'b0;
        end
    end

    sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_reg != ST_HOLD),
        .en    (state_reg == ST_HOLD),
        .count (hold_cnt)
    );

    sat_counter #(.WIDTH(32)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_load),
        .en    ((state_reg == ST_RUN) && !abort),
        .count (cycle_cnt)
    );

    assign ld_bus.ld_ready   = (state_reg == ST_LOAD);
    assign ld_bus.imem_we    = accept;
    assign ld_bus.imem_addr  = addr_reg;
    assign ld_bus.imem_wdata = ld_bus.ld_data;

    assign core_rst = (state_reg == ST_IDLE) || (state_reg == ST_LOAD) || (state_reg == ST_HOLD);
    assign core_en  = (state_reg == ST_RUN);
    assign busy     = (state_reg == ST_LOAD) || (state_reg == ST_HOLD) || (state_reg == ST_RUN);
    assign done     = done_reg;
    assign timeout  = timeout_reg;
    assign load_ovf = ovf_reg;

endmodule

// File: tb/tb_boot_ctrl.sv
// Directed bench for boot_ctrl: a default instance (unlimited run) and a small
// instance (4-word memory, 5-cycle limit) driven through a linear sequence.
`timescale 1ns/1ps
module tb_boot_ctrl;

    localparam logic [31:0] HALT = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: ADDR_W=8, unlimited run
    logic        a_start, a_abort, a_instr_valid;
    logic [31:0] a_instr;
    logic        a_core_rst, a_core_en, a_done, a_timeout, a_ovf, a_busy;
    logic [31:0] a_cycle_cnt;
    boot_ctrl_if #(.ADDR_W(8), .DATA_W(32)) a_bus ();

    boot_ctrl #(.ADDR_W(8), .DATA_W(32), .RST_HOLD(2), .MAX_CYCLES(32'd0)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (a_start),
        .abort       (a_abort),
        .ld_bus      (a_bus),
        .core_rst    (a_core_rst),
        .core_en     (a_core_en),
        .instr_valid (a_instr_valid),
        .instr_i     (a_instr),
        .cycle_cnt   (a_cycle_cnt),
        .done        (a_done),
        .timeout     (a_timeout),
        .load_ovf    (a_ovf),
        .busy        (a_busy)
    );

    // Instance B: ADDR_W=2, MAX_CYCLES=5
    logic        b_start, b_abort, b_instr_valid;
    logic [31:0] b_instr;
    logic        b_core_rst, b_core_en, b_done, b_timeout, b_ovf, b_busy;
    logic [31:0] b_cycle_cnt;
    boot_ctrl_if #(.ADDR_W(2), .DATA_W(32)) b_bus ();

    boot_ctrl #(.ADDR_W(2), .DATA_W(32), .RST_HOLD(2), .MAX_CYCLES(32'd5)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (b_start),
        .abort       (b_abort),
        .ld_bus      (b_bus),
        .core_rst    (b_core_rst),
        .core_en     (b_core_en),
        .instr_valid (b_instr_valid),
        .instr_i     (b_instr),
        .cycle_cnt   (b_cycle_cnt),
        .done        (b_done),
        .timeout     (b_timeout),
        .load_ovf    (b_ovf),
        .busy        (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_busy"},     32'(a_busy), 32'd0);
        check({tag, "_core_rst"}, 32'(a_core_rst), 32'd1);
        check({tag, "_core_en"},  32'(a_core_en), 32'd0);
        check({tag, "_ld_ready"}, 32'(a_bus.ld_ready), 32'd0);
        check({tag, "_imem_we"},  32'(a_bus.imem_we), 32'd0);
        check({tag, "_addr"},     32'(a_bus.imem_addr), 32'd0);
        check({tag, "_cycle"},    a_cycle_cnt, 32'd0);
        check({tag, "_flags"},    {29'd0, a_done, a_timeout, a_ovf}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_instr_valid = 1'b0; a_instr = NOP;
        b_start = 1'b0; b_abort = 1'b0; b_instr_valid = 1'b0; b_instr = NOP;
        a_bus.ld_valid = 1'b0; a_bus.ld_data = '0; a_bus.ld_last = 1'b0;
        b_bus.ld_valid = 1'b0; b_bus.ld_data = '0; b_bus.ld_last = 1'b0;

        // Reset takes effect before any clock edge
        #2 rst = 1'b1;
        #1;
        check_reset_a("rst_async");
        check("b_rst_core_rst", 32'(b_core_rst), 32'd1);
        tick();
        tick();
        rst = 1'b0;

        // ---------------- Instance A: 4-word load, hold, run to halt ----------------
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        #1;
        check("a_load_ready", 32'(a_bus.ld_ready), 32'd1);
        check("a_load_busy", 32'(a_busy), 32'd1);
        check("a_load_core_rst", 32'(a_core_rst), 32'd1);
        for (int i = 0; i < 4; i++) begin
            a_bus.ld_valid = 1'b1;
            a_bus.ld_data  = 32'hA5A5_0000 + i;
            a_bus.ld_last  = (i == 3);
            #1;
            $display("A load word %0d: we=%0b addr=%0d data=%h", i, a_bus.imem_we, a_bus.imem_addr, a_bus.imem_wdata);
            check("a_load_we", 32'(a_bus.imem_we), 32'd1);
            check("a_load_addr", 32'(a_bus.imem_addr), 32'(i));
            check("a_load_wdata", a_bus.imem_wdata, 32'hA5A5_0000 + i);
            tick();
        end
        // HOLD cycle 1: stray ld_valid and start must have no effect
        a_bus.ld_last = 1'b0;
        a_start = 1'b1;
        #1;
        check("a_hold_we", 32'(a_bus.imem_we), 32'd0);
        check("a_hold_ready", 32'(a_bus.ld_ready), 32'd0);
        check("a_hold1_core_en", 32'(a_core_en), 32'd0);
        check("a_hold1_core_rst", 32'(a_core_rst), 32'd1);
        tick();
        a_start = 1'b0;
        a_bus.ld_valid = 1'b0;
        #1;
        check("a_hold2_core_en", 32'(a_core_en), 32'd0);
        check("a_hold2_busy", 32'(a_busy), 32'd1);
        tick();
        check("a_run_core_en", 32'(a_core_en), 32'd1);
        check("a_run_core_rst", 32'(a_core_rst), 32'd0);
        check("a_run_cycle0", a_cycle_cnt, 32'd0);

        // Halt on RUN cycle 10; a halt word without instr_valid on cycle 4 is ignored
        for (int c = 1; c <= 10; c++) begin
            a_start       = (c == 3);
            a_instr_valid = (c != 4);
            a_instr       = (c == 4 || c == 10) ? HALT : NOP;
            #1;
            if (c == 5) begin
                check("a_run_cycle4", a_cycle_cnt, 32'd4);
                check("a_run_busy", 32'(a_busy), 32'd1);
            end
            tick();
        end
        a_start = 1'b0;
        a_instr_valid = 1'b0;
        a_instr = NOP;
        #1;
        $display("A halt: done=%0b timeout=%0b cycle_cnt=%0d core_en=%0b", a_done, a_timeout, a_cycle_cnt, a_core_en);
        check("a_halt_done", 32'(a_done), 32'd1);
        check("a_halt_timeout", 32'(a_timeout), 32'd0);
        check("a_halt_cycle", a_cycle_cnt, 32'd10);
        check("a_halt_core_en", 32'(a_core_en), 32'd0);
        check("a_halt_core_rst", 32'(a_core_rst), 32'd0);
        check("a_halt_busy", 32'(a_busy), 32'd0);
        tick();
        check("a_done_hold_done", 32'(a_done), 32'd1);
        check("a_done_hold_cycle", a_cycle_cnt, 32'd10);

        // Restart from DONE, then abort mid-RUN while a halt is presented
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        #1;
        check("a_restart_done", 32'(a_done), 32'd0);
        check("a_restart_cycle", a_cycle_cnt, 32'd0);
        check("a_restart_addr", 32'(a_bus.imem_addr), 32'd0);
        for (int i = 0; i < 2; i++) begin
            a_bus.ld_valid = 1'b1;
            a_bus.ld_data  = 32'hC0DE_0000 + i;
            a_bus.ld_last  = (i == 1);
            tick();
        end
        a_bus.ld_valid = 1'b0;
        a_bus.ld_last = 1'b0;
        tick();
        tick();
        check("a_run2_core_en", 32'(a_core_en), 32'd1);
        tick();
        tick();
        tick();
        a_abort = 1'b1;
        a_instr_valid = 1'b1;
        a_instr = HALT;
        tick();
        a_abort = 1'b0;
        a_instr_valid = 1'b0;
        a_instr = NOP;
        #1;
        $display("A abort: busy=%0b core_rst=%0b done=%0b", a_busy, a_core_rst, a_done);
        check("a_abort_busy", 32'(a_busy), 32'd0);
        check("a_abort_core_rst", 32'(a_core_rst), 32'd1);
        check("a_abort_core_en", 32'(a_core_en), 32'd0);
        check("a_abort_done", 32'(a_done), 32'd0);

        // Reset in the middle of a load
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_bus.ld_valid = 1'b1;
            a_bus.ld_data  = 32'h1234_0000 + i;
            tick();
        end
        #1;
        check("a_midload_addr", 32'(a_bus.imem_addr), 32'd2);
        rst = 1'b1;
        #1;
        check_reset_a("a_midload_rst");
        rst = 1'b0;
        #1;
        check("a_rst_release_we", 32'(a_bus.imem_we), 32'd0);
        tick();
        check("a_after_rst_we", 32'(a_bus.imem_we), 32'd0);
        check("a_after_rst_busy", 32'(a_busy), 32'd0);
        a_bus.ld_valid = 1'b0;

        // ---------------- Instance B: overflow, timeout, halt at limit ----------------
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_bus.ld_valid = 1'b1;
            b_bus.ld_data  = 32'hB000_0000 + i;
            b_bus.ld_last  = 1'b0;
            #1;
            $display("B load word %0d: ready=%0b we=%0b addr=%0d ovf=%0b", i, b_bus.ld_ready, b_bus.imem_we, b_bus.imem_addr, b_ovf);
            if (i < 4) begin
                check("b_ovf_we", 32'(b_bus.imem_we), 32'd1);
                check("b_ovf_addr", 32'(b_bus.imem_addr), 32'(i));
            end else begin
                check("b_5th_ready", 32'(b_bus.ld_ready), 32'd0);
                check("b_5th_we", 32'(b_bus.imem_we), 32'd0);
                check("b_load_ovf", 32'(b_ovf), 32'd1);
            end
            tick();
        end
        b_bus.ld_valid = 1'b0;
        tick();
        check("b_run_core_en", 32'(b_core_en), 32'd1);
        check("b_no_wrap_addr", 32'(b_bus.imem_addr), 32'd3);

        for (int c = 1; c <= 5; c++) begin
            b_instr_valid = 1'b1;
            b_instr = NOP;
            #1;
            if (c == 5) begin
                check("b_to_busy", 32'(b_busy), 32'd1);
                check("b_to_cycle4", b_cycle_cnt, 32'd4);
            end
            tick();
        end
        b_instr_valid = 1'b0;
        #1;
        $display("B timeout: done=%0b timeout=%0b cycle_cnt=%0d", b_done, b_timeout, b_cycle_cnt);
        check("b_to_done", 32'(b_done), 32'd1);
        check("b_to_timeout", 32'(b_timeout), 32'd1);
        check("b_to_cycle", b_cycle_cnt, 32'd5);
        check("b_to_core_en", 32'(b_core_en), 32'd0);

        // Halt coinciding with the cycle limit: halt wins
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        #1;
        check("b_restart_ovf", 32'(b_ovf), 32'd0);
        check("b_restart_timeout", 32'(b_timeout), 32'd0);
        for (int i = 0; i < 4; i++) begin
            b_bus.ld_valid = 1'b1;
            b_bus.ld_data  = 32'hB100_0000 + i;
            b_bus.ld_last  = (i == 3);
            tick();
        end
        b_bus.ld_valid = 1'b0;
        b_bus.ld_last = 1'b0;
        check("b_last_at_max_ovf", 32'(b_ovf), 32'd0);
        tick();
        tick();
        for (int c = 1; c <= 5; c++) begin
            b_instr_valid = 1'b1;
            b_instr = (c == 5) ? HALT : NOP;
            tick();
        end
        b_instr_valid = 1'b0;
        b_instr = NOP;
        #1;
        $display("B halt at limit: done=%0b timeout=%0b cycle_cnt=%0d", b_done, b_timeout, b_cycle_cnt);
        check("b_halt_done", 32'(b_done), 32'd1);
        check("b_halt_timeout", 32'(b_timeout), 32'd0);
        check("b_halt_cycle", b_cycle_cnt, 32'd5);

        // Abort mid-RUN keeps load_ovf; abort beats start in IDLE
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_bus.ld_valid = 1'b1;
            b_bus.ld_data  = 32'hB200_0000 + i;
            b_bus.ld_last  = 1'b0;
            tick();
        end
        b_bus.ld_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("b_abort_pre_run", 32'(b_core_en), 32'd1);
        b_abort = 1'b1;
        tick();
        b_abort = 1'b0;
        #1;
        $display("B abort: busy=%0b core_rst=%0b load_ovf=%0b", b_busy, b_core_rst, b_ovf);
        check("b_abort_busy", 32'(b_busy), 32'd0);
        check("b_abort_core_rst", 32'(b_core_rst), 32'd1);
        check("b_abort_ovf_kept", 32'(b_ovf), 32'd1);
        b_start = 1'b1;
        b_abort = 1'b1;
        tick();
        b_start = 1'b0;
        b_abort = 1'b0;
        #1;
        check("b_abort_vs_start_busy", 32'(b_busy), 32'd0);
        check("b_abort_vs_start_ovf", 32'(b_ovf), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_ctrl.md
BOOT_CTRL -- requirements
Module: boot_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the instruction word width.
REQ-003 SHALL have parameter RST_HOLD, default 2, meaning the number of cycles (>=1) core_rst is held after loading.
REQ-004 SHALL have parameter MAX_CYCLES, default 0, meaning the run-cycle limit (0 = unlimited).
REQ-005 SHALL have parameter HALT_INSTR, default 32'h00100073 (ebreak), meaning the instruction that ends a run.
REQ-006 SHALL have ports: clk  in  1  clock, all logic on the rising edge.
REQ-007 SHALL have ports: rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-008 SHALL have ports: start in 1 (begin load); abort in 1 (return to IDLE); ld_valid in 1; ld_data in DATA_W; ld_last in 1 (final word).
REQ-009 SHALL have ports: ld_ready out 1; imem_we out 1; imem_addr out ADDR_W; imem_wdata out DATA_W.
REQ-010 SHALL have ports: core_rst out 1 (active-high core reset); core_en out 1; instr_valid in 1; instr_i in DATA_W (core fetch monitor).
REQ-011 SHALL have ports: cycle_cnt out 32; done out 1; timeout out 1; load_ovf out 1; busy out 1.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, HOLD, RUN, DONE.
REQ-013 In IDLE: core_rst=1, core_en=0, ld_ready=0; start -> LOAD, clearing the load address, cycle_cnt, done, timeout and load_ovf.
REQ-014 In LOAD: ld_ready=1; each ld_valid&ld_ready cycle drives imem_we=1, imem_wdata=ld_data and imem_addr=current address, combinationally in that same cycle; the address increments by 1.
REQ-015 In LOAD: an accepted word with ld_last=1 -> HOLD.
REQ-016 In LOAD: an accepted word at address 2^ADDR_W-1 with ld_last=0 -> HOLD, sets load_ovf=1, and the address does not wrap.
REQ-017 In HOLD: core_rst=1, core_en=0, ld_ready=0, for exactly RST_HOLD cycles, then -> RUN.
REQ-018 In RUN: core_rst=0, core_en=1; cycle_cnt increments by 1 per RUN cycle and saturates at 32'hFFFFFFFF.
REQ-019 In RUN: instr_valid=1 with instr_i==HALT_INSTR -> DONE with done=1.
REQ-020 In RUN: if MAX_CYCLES!=0 and the incremented cycle_cnt reaches MAX_CYCLES -> DONE with done=1 and timeout=1.
REQ-021 When halt and timeout occur in the same cycle, halt SHALL win (timeout=0).
REQ-022 In DONE: core_en=0, core_rst=0 (core state held for inspection); flags and cycle_cnt hold; start -> LOAD per REQ-013.
REQ-023 start in LOAD, HOLD or RUN SHALL be ignored.
REQ-024 abort in any state SHALL -> IDLE on the next edge (clearing no flags); abort SHALL win over start and over every other transition.
REQ-025 busy SHALL be 1 in LOAD, HOLD and RUN, and 0 otherwise.
REQ-026 imem_we SHALL never be 1 outside LOAD.

Reset
REQ-027 rst=1 SHALL force IDLE asynchronously; the address, cycle_cnt, done, timeout, load_ovf, ld_ready, imem_we, core_en and busy SHALL reset to 0, and core_rst to 1.
REQ-028 rst asserted mid-LOAD or mid-RUN SHALL abandon the operation; no imem write SHALL occur in the cycle of rst deassertion.

Structure
REQ-029 The state encoding (3-bit typedef) and the HALT_INSTR default SHALL live in the shared package rv32i_pkg.
REQ-030 The HOLD/RUN counting SHALL be a single sub-module, sat_counter (parametrised width, clear, enable, saturate), used for both the hold count and cycle_cnt.

Verification
REQ-031 rst pulse, then start and 4 words (ld_last on the 4th) -> imem writes to addresses 0..3, HOLD of 2 cycles, then core_en=1.
REQ-032 In RUN, instr_valid=1 with instr_i=32'h00100073 at cycle 10 -> done=1, timeout=0, cycle_cnt=10, core_en=0 on the next cycle.
REQ-033 MAX_CYCLES=5 with no halt -> DONE after 5 RUN cycles, timeout=1, cycle_cnt=5.
REQ-034 ADDR_W=2 with 5 words streamed and no ld_last -> 4 writes (addresses 0..3), load_ovf=1, 5th word not accepted (ld_ready=0).
REQ-035 MAX_CYCLES=5 with the halt instruction on the 5th RUN cycle -> done=1, timeout=0.
REQ-036 abort mid-RUN -> IDLE, core_rst=1, flags retained; rst mid-LOAD -> all outputs at reset values immediately.
